// File: rtl/reg_file_sb.sv
// 32x32 register file with write-back bypass and a pending-write scoreboard.
// Issue stalls on RAW/WAW hazards against registers still awaiting write-back.
module reg_file_sb (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [4:0]  Rs1_Addr,
  input  logic [4:0]  Rs2_Addr,
  input  logic        Rs1_Use,
  input  logic        Rs2_Use,
  output logic [31:0] Rs1_Data,
  output logic [31:0] Rs2_Data,
  input  logic        Issue_Valid,
  input  logic [4:0]  Issue_Rd,
  input  logic        Wb_Valid,
  input  logic [4:0]  Wb_Rd,
  input  logic [31:0] Wb_Data,
  output logic        Stall,
  output logic [5:0]  Pending_Cnt,
  output logic        Wb_Err
);

  logic [31:0] regs_q [32];
  logic [31:0] pend_q, pend_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        wb_wr, byp1, byp2;
  logic        haz1, haz2, waw, accept;

  assign wb_wr = Wb_Valid && (Wb_Rd != 5'd0);
  assign byp1  = wb_wr && (Wb_Rd == Rs1_Addr);
  assign byp2  = wb_wr && (Wb_Rd == Rs2_Addr);

  // x0 is never written, so regs_q[0] stays at its reset value of 0
  assign Rs1_Data = byp1 ? Wb_Data : regs_q[Rs1_Addr];
  assign Rs2_Data = byp2 ? Wb_Data : regs_q[Rs2_Addr];

  assign haz1 = Rs1_Use && (Rs1_Addr != 5'd0)
             && pend_q[Rs1_Addr]
             && !(Wb_Valid && (Wb_Rd == Rs1_Addr));
  assign haz2 = Rs2_Use && (Rs2_Addr != 5'd0)
             && pend_q[Rs2_Addr]
             && !(Wb_Valid && (Wb_Rd == Rs2_Addr));
  assign waw  = (Issue_Rd != 5'd0)
             && pend_q[Issue_Rd]
             && !(Wb_Valid && (Wb_Rd == Issue_Rd));

  assign Stall  = Issue_Valid && (haz1 || haz2 || waw);
  assign accept = Issue_Valid && !Stall
               && (Issue_Rd != 5'd0);

  always_comb begin
    pend_d = pend_q;
    // clear first so a same-register set wins
    if (Wb_Valid) pend_d[Wb_Rd] = 1'b0;
    if (accept)   pend_d[Issue_Rd] = 1'b1;
    pend_d[0] = 1'b0;
    cnt_d = 6'd0;
    for (int i = 0; i < 32; i++)
      cnt_d = cnt_d + {5'd0, pend_d[i]};
    err_d = err_q || (wb_wr && !pend_q[Wb_Rd]);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 32; i++)
        regs_q[i] <= '0;
    end else if (wb_wr) begin
      regs_q[Wb_Rd] <= Wb_Data;
    end
  end

  assign Pending_Cnt = cnt_q;
  assign Wb_Err      = err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios then random traffic,
// all checked against an array/bitmap model of the scoreboard.
module tb_reg_file_sb;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [4:0]  Rs1_Addr, Rs2_Addr;
  logic        Rs1_Use, Rs2_Use;
  logic [31:0] Rs1_Data, Rs2_Data;
  logic        Issue_Valid;
  logic [4:0]  Issue_Rd;
  logic        Wb_Valid;
  logic [4:0]  Wb_Rd;
  logic [31:0] Wb_Data;
  logic        Stall;
  logic [5:0]  Pending_Cnt;
  logic        Wb_Err;

  reg_file_sb dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Rs1_Addr(Rs1_Addr), .Rs2_Addr(Rs2_Addr),
    .Rs1_Use(Rs1_Use), .Rs2_Use(Rs2_Use),
    .Rs1_Data(Rs1_Data), .Rs2_Data(Rs2_Data),
    .Issue_Valid(Issue_Valid), .Issue_Rd(Issue_Rd),
    .Wb_Valid(Wb_Valid), .Wb_Rd(Wb_Rd), .Wb_Data(Wb_Data),
    .Stall(Stall), .Pending_Cnt(Pending_Cnt), .Wb_Err(Wb_Err)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  // reference model
  logic [31:0] mreg [32];
  bit          mpend [32];
  bit          merr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int npend();
    int n = 0;
    foreach (mpend[i]) if (mpend[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (Wb_Valid && Wb_Rd == a) return Wb_Data;
    return mreg[a];
  endfunction

  // a register is "busy" if pending and not being written back now
  function automatic bit busy(input logic [4:0] a);
    return a != 0 && mpend[a] && !(Wb_Valid && Wb_Rd == a);
  endfunction

  function automatic bit m_stall();
    if (!Issue_Valid) return 1'b0;
    return (Rs1_Use && busy(Rs1_Addr)) || (Rs2_Use && busy(Rs2_Addr))
        || busy(Issue_Rd);
  endfunction

  task automatic m_reset();
    foreach (mreg[i]) mreg[i] = '0;
    foreach (mpend[i]) mpend[i] = 1'b0;
    merr = 1'b0;
  endtask

  // Drive one cycle, check comb outputs, clock it, check registered outputs.
  task automatic step(input bit iv, input logic [4:0] ird,
                      input logic [4:0] r1, input bit u1,
                      input logic [4:0] r2, input bit u2,
                      input bit wv, input logic [4:0] wrd,
                      input logic [31:0] wd);
    bit st;
    Issue_Valid = iv; Issue_Rd = ird;
    Rs1_Addr = r1; Rs1_Use = u1;
    Rs2_Addr = r2; Rs2_Use = u2;
    Wb_Valid = wv; Wb_Rd = wrd; Wb_Data = wd;
    #2;
    st = m_stall();
    chk("stall", {31'd0, Stall}, {31'd0, st});
    chk("rs1", Rs1_Data, m_read(r1));
    chk("rs2", Rs2_Data, m_read(r2));
    chk("cnt_pre", {26'd0, Pending_Cnt}, npend());
    @(posedge Clk);
    if (wv && wrd != 0) begin
      if (!mpend[wrd]) merr = 1'b1;
      mreg[wrd] = wd;
    end
    if (wv) mpend[wrd] = 1'b0;
    if (iv && !st && ird != 0) mpend[ird] = 1'b1;
    #1;
    chk("cnt", {26'd0, Pending_Cnt}, npend());
    chk("err", {31'd0, Wb_Err}, {31'd0, merr});
  endtask

  task automatic idle_rd(input logic [4:0] r1, input logic [4:0] r2);
    step(0, 0, r1, 0, r2, 0, 0, 0, 0);
  endtask

  initial begin
    Rst_n = 1'b0;
    Issue_Valid = 0; Issue_Rd = 0;
    Rs1_Addr = 0; Rs1_Use = 0; Rs2_Addr = 0; Rs2_Use = 0;
    Wb_Valid = 0; Wb_Rd = 0; Wb_Data = 0;
    m_reset();
    #1;
    chk("rst_cnt", {26'd0, Pending_Cnt}, 32'd0);
    chk("rst_err", {31'd0, Wb_Err}, 32'd0);
    Rs1_Addr = 5'd12; Issue_Valid = 1; Issue_Rd = 5'd12;
    #1;
    chk("rst_rs1", Rs1_Data, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    Issue_Valid = 0;
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    // bypass then array read of a freshly written register
    step(1, 5, 0, 0, 0, 0, 0, 0, 0);
    Issue_Valid = 0; Rs1_Addr = 5; Wb_Valid = 1; Wb_Rd = 5;
    Wb_Data = 32'hAA;
    #1;
    chk("byp5", Rs1_Data, 32'hAA);
    step(0, 0, 5, 1, 0, 0, 1, 5, 32'hAA);
    idle_rd(5, 5);
    chk("reg5", Rs1_Data, 32'hAA);
    idle_rd(5, 0);
    chk("reg5b", Rs1_Data, 32'hAA);

    // RAW stall on rd=10, released by same-cycle write-back
    step(1, 10, 0, 0, 0, 0, 0, 0, 0);
    step(1, 11, 0, 0, 10, 1, 0, 0, 0);
    chk("raw_cnt", {26'd0, Pending_Cnt}, 32'd1);
    Issue_Valid = 1; Issue_Rd = 11; Rs2_Addr = 10; Rs2_Use = 1;
    Wb_Valid = 1; Wb_Rd = 10; Wb_Data = 32'h1234_5678;
    #1;
    chk("raw_stall", {31'd0, Stall}, 32'd1 - 32'd1);
    chk("raw_byp", Rs2_Data, 32'h1234_5678);
    step(1, 11, 0, 0, 10, 1, 1, 10, 32'h1234_5678);
    step(0, 0, 0, 0, 0, 0, 1, 11, 32'h11);

    // write-back to x0 is dropped
    step(0, 0, 0, 1, 0, 0, 1, 0, 32'hFFFF_FFFF);
    chk("x0_rd", Rs1_Data, 32'd0);
    chk("x0_cnt", {26'd0, Pending_Cnt}, 32'd0);
    chk("x0_err", {31'd0, Wb_Err}, 32'd0);

    // same-cycle set and clear of rd=7: set wins
    step(1, 7, 0, 0, 0, 0, 0, 0, 0);
    step(1, 7, 0, 0, 0, 0, 1, 7, 32'h77);
    chk("sc_cnt", {26'd0, Pending_Cnt}, 32'd1);
    step(1, 0, 7, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7, 32'h78);

    // mid-cycle reset discards three pending destinations
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0, 0, 0);
    chk("three_cnt", {26'd0, Pending_Cnt}, 32'd3);
    Issue_Valid = 0; Wb_Valid = 0;
    Rs1_Addr = 5; Rs2_Addr = 7;
    #2;
    Rst_n = 1'b0;
    m_reset();
    #1;
    chk("mr_cnt", {26'd0, Pending_Cnt}, 32'd0);
    chk("mr_rs1", Rs1_Data, 32'd0);
    chk("mr_rs2", Rs2_Data, 32'd0);
    chk("mr_err", {31'd0, Wb_Err}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    step(1, 3, 3, 1, 0, 0, 0, 0, 0);
    chk("post_cnt", {26'd0, Pending_Cnt}, 32'd1);

    // write-back to a non-pending register
    step(0, 0, 0, 0, 0, 0, 1, 9, 32'h9999);
    chk("err9", {31'd0, Wb_Err}, 32'd1);
    idle_rd(9, 3);
    chk("reg9", Rs1_Data, 32'h9999);
    idle_rd(0, 0);
    chk("err9_hold", {31'd0, Wb_Err}, 32'd1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr;
      wr = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0)
        for (int k = 0; k < 32; k++)
          if (mpend[k] && $urandom_range(0, 2) == 0) wr = 5'(k);
      step(1'($urandom), 5'($urandom),
           5'($urandom), 1'($urandom),
           5'($urandom), 1'($urandom),
           1'($urandom), wr, $urandom);
    end

    Rst_n = 1'b0;
    m_reset();
    #1;
    chk("end_err", {31'd0, Wb_Err}, 32'd0);
    chk("end_cnt", {26'd0, Pending_Cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port Rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have ports Rs1_Addr and Rs2_Addr, input, 5 bits each: source register addresses.
REQ-004 SHALL have ports Rs1_Use and Rs2_Use, input, 1 bit each: the issuing instruction reads Rs1 / Rs2.
REQ-005 SHALL have ports Rs1_Data and Rs2_Data, output, 32 bits each: combinational read data.
REQ-006 SHALL have port Issue_Valid, input, 1 bit: an instruction requests issue this cycle.
REQ-007 SHALL have port Issue_Rd, input, 5 bits: destination register from the 5-bit destination-select mux.
REQ-008 SHALL have ports Wb_Valid (1 bit), Wb_Rd (5 bits) and Wb_Data (32 bits), input: write-back request.
REQ-009 SHALL have port Stall, output, 1 bit: issue blocked this cycle (combinational).
REQ-010 SHALL have port Pending_Cnt, output, 6 bits, registered: number of registers awaiting write-back.
REQ-011 SHALL have port Wb_Err, output, 1 bit, sticky: write-back seen to a non-pending register.

Function
REQ-012 SHALL hold 32 x 32-bit registers; x0 SHALL always read 0, ignore writes and never be pending.
REQ-013 SHALL write Wb_Data into reg[Wb_Rd] on the rising edge when Wb_Valid=1 and Wb_Rd!=0.
REQ-014 SHALL drive RsN_Data = Wb_Data (bypass) when Wb_Valid=1, Wb_Rd=RsN_Addr and RsN_Addr!=0; otherwise RsN_Data = reg[RsN_Addr].
REQ-015 SHALL keep a 32-bit Pending vector; an issue accept (Issue_Valid=1, Stall=0, Issue_Rd!=0) SHALL set Pending[Issue_Rd] at the edge.
REQ-016 SHALL clear Pending[Wb_Rd] at the edge when Wb_Valid=1.
REQ-017 When a set and a clear target the same register in the same cycle, the set SHALL win.
REQ-018 SHALL define the source hazard for N in {1,2} as RsN_Use & RsN_Addr!=0 & Pending[RsN_Addr] & !(Wb_Valid & Wb_Rd=RsN_Addr).
REQ-019 SHALL define the WAW hazard as Issue_Rd!=0 & Pending[Issue_Rd] & !(Wb_Valid & Wb_Rd=Issue_Rd).
REQ-020 SHALL drive Stall = Issue_Valid & (source hazard on Rs1 | source hazard on Rs2 | WAW hazard).
REQ-021 Stall SHALL be 0 whenever Issue_Valid=0.
REQ-022 Pending_Cnt SHALL equal the population count of Pending after each edge; range 0..31, no wrap.
REQ-023 When Wb_Valid=1, Wb_Rd!=0 and Pending[Wb_Rd]=0, the register SHALL still be written and Wb_Err SHALL be set to 1 at the edge, holding until reset.
REQ-024 Write-back latency SHALL be zero for same-cycle readers (bypass) and one cycle for the register array.
REQ-025 A stalled issue SHALL leave Pending unchanged.

Reset
REQ-026 Rst_n=0 SHALL immediately clear all registers, Pending, Pending_Cnt and Wb_Err to 0, independent of Clk.
REQ-027 A reset asserted mid-operation SHALL discard all in-flight pending state; the first edge after Rst_n returns to 1 SHALL behave as from the empty state.
REQ-028 After reset, Stall SHALL be 0 for any issue and Rs1_Data/Rs2_Data SHALL be 0 with no write-back active.

Verification
REQ-029 The bench SHALL check: write-back Wb_Rd=5, Wb_Data=0x0000_00AA, then read Rs1_Addr=5 -> Rs1_Data=0xAA in the same cycle (bypass) and on every later cycle.
REQ-030 The bench SHALL check: issue Rd=10 accepted, next cycle issue with Rs2_Addr=10, Rs2_Use=1 -> Stall=1 and Pending_Cnt=1; then Wb_Rd=10 -> Stall=0 in that cycle and Rs2_Data=Wb_Data.
REQ-031 The bench SHALL check: Wb_Rd=0, Wb_Data=0xFFFF_FFFF -> Rs1_Data for address 0 stays 0, Pending_Cnt unchanged and Wb_Err stays 0.
REQ-032 The bench SHALL check: issue Rd=7 accepted in the same cycle as Wb_Rd=7 -> Pending[7]=1 and Pending_Cnt unchanged.
REQ-033 The bench SHALL check: issue 3 destinations (Pending_Cnt=3), assert Rst_n=0 between edges -> outputs read 0 immediately, and issue Rd=3 after release -> no stall.
REQ-034 The bench SHALL check: Wb_Rd=9 with Pending[9]=0 -> reg 9 is written and Wb_Err=1, remaining 1 until reset.
